// File: rtl/adder_deserializer.sv
// Serial-to-parallel front end for the adder tree.
// Collects NUM samples of BITS bits into one parallel vector and presents it
// for one cycle with valid_out, either when the vector fills or on flush.
// lane_mask marks which lanes carry real samples; unused lanes read as zero.
module adder_deserializer #(
  parameter int BITS = 8,
  parameter int NUM  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid,
  input  logic [BITS-1:0]          data_in,
  input  logic                     flush,
  output logic [BITS*NUM-1:0]      data_out,
  output logic [NUM-1:0]           lane_mask,
  output logic                     valid_out,
  output logic [$clog2(NUM):0]     fill
);

  localparam int FW = $clog2(NUM) + 1;

  // Write pointer; doubles as the count of samples in the open vector.
  logic [FW-1:0]       fill_reg;
  // Shadow buffer holding the samples of the vector being collected.
  logic [BITS-1:0]     shadow_reg [NUM];
  logic [BITS*NUM-1:0] data_out_reg;
  logic [NUM-1:0]      lane_mask_reg;
  logic                valid_out_reg;

  // Vector and mask as they would look if emitted at this edge, i.e. the
  // shadow content with the current sample (if any) merged into lane fill.
  logic [BITS*NUM-1:0] vec_next;
  logic [NUM-1:0]      mask_next;
  logic [NUM-1:0]      lane_hit;

  logic emit_full;
  logic emit_flush;
  logic emit;

  // A full vector closes on the NUM-th sample; a flush closes whatever is
  // open, including a sample arriving in the same cycle. A flush with nothing
  // held and nothing arriving is ignored.
  assign emit_full  = valid && (fill_reg == FW'(NUM - 1));
  assign emit_flush = flush && ((fill_reg != '0) || valid);
  assign emit       = emit_full || emit_flush;

  generate
    for (genvar gi = 0; gi < NUM; gi++) begin : g_lane
      // This lane is the write target of the incoming sample.
      assign lane_hit[gi] = valid && (fill_reg == FW'(gi));

      // Lanes beyond the fill point are already zero in the shadow buffer,
      // so a partial vector comes out zero-padded without extra muxing.
      assign vec_next[gi*BITS +: BITS] = lane_hit[gi] ? data_in : shadow_reg[gi];

      // Lane holds a real sample if it was written earlier or is written now.
      assign mask_next[gi] = (FW'(gi) < fill_reg) || lane_hit[gi];

      // Per-lane shadow storage: capture on hit, clear whenever a vector leaves.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          shadow_reg[gi] <= '0;
        end else if (emit) begin
          shadow_reg[gi] <= '0;
        end else if (lane_hit[gi]) begin
          shadow_reg[gi] <= data_in;
        end
      end
    end
  endgenerate

  // Fill counter and registered output vector, mask and one-cycle pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_reg      <= '0;
      data_out_reg  <= '0;
      lane_mask_reg <= '0;
      valid_out_reg <= 1'b0;
    end else begin
      valid_out_reg <= emit;
      if (emit) begin
        data_out_reg  <= vec_next;
        lane_mask_reg <= mask_next;
        fill_reg      <= '0;
      end else if (valid) begin
        fill_reg <= fill_reg + FW'(1);
      end
    end
  end

  assign data_out  = data_out_reg;
  assign lane_mask = lane_mask_reg;
  assign valid_out = valid_out_reg;
  assign fill      = fill_reg;

endmodule

// File: tb/tb_adder_deserializer.sv
// Directed bench for adder_deserializer: a table of fill/flush transactions
// plus hand-written multi-cycle sequences (gaps, mid-fill reset, back-to-back).
module tb_adder_deserializer;

  localparam int BITS = 8;
  localparam int NUM  = 32;
  localparam int FW   = $clog2(NUM) + 1;
  localparam int VW   = BITS * NUM;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            valid = 1'b0;
  logic [BITS-1:0] data_in = '0;
  logic            flush = 1'b0;
  logic [VW-1:0]   data_out;
  logic [NUM-1:0]  lane_mask;
  logic            valid_out;
  logic [FW-1:0]   fill;

  adder_deserializer #(.BITS(BITS), .NUM(NUM)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (valid),
    .data_in   (data_in),
    .flush     (flush),
    .data_out  (data_out),
    .lane_mask (lane_mask),
    .valid_out (valid_out),
    .fill      (fill)
  );

  always #5 clk = ~clk;

  int vec_cnt   = 0;
  int err_cnt   = 0;
  int cycle     = 0;
  int pulse_cnt = 0;
  int pulse_cyc = 0;
  logic [VW-1:0]  cap_data = '0;
  logic [NUM-1:0] cap_mask = '0;

  typedef struct {
    int             n;
    logic [7:0]     base;
    logic           flush_last;
    logic           flush_after;
    int             exp_pulses;
    logic [NUM-1:0] exp_mask;
  } tvec_t;

  tvec_t tbl [7];

  // One clock: drive inputs, take the edge, look at outputs 1ns later.
  task automatic cyc(input logic v, input logic [BITS-1:0] d, input logic f);
    valid   = v;
    data_in = d;
    flush   = f;
    @(posedge clk);
    #1;
    cycle++;
    if (valid_out) begin
      pulse_cnt++;
      pulse_cyc = cycle;
      cap_data  = data_out;
      cap_mask  = lane_mask;
    end
    valid   = 1'b0;
    flush   = 1'b0;
    data_in = '0;
  endtask

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected vector: lanes 0..n-1 hold base, base+step, ...; other lanes zero.
  function automatic logic [VW-1:0] mkvec(input int n, input logic [7:0] base, input logic [7:0] step);
    logic [VW-1:0] v;
    logic [7:0]    x;
    v = '0;
    x = base;
    for (int i = 0; i < n; i++) begin
      v[i*BITS +: BITS] = x;
      x = x + step;
    end
    return v;
  endfunction

  initial begin
    int p0;
    int c1;
    int c2;
    logic [7:0] sum;
    logic [VW-1:0] prev_exp;

    //            n   base   fl_last fl_after pulses mask
    tbl[0] = '{5,  8'hA0, 1'b0, 1'b1, 1, 32'h0000_001F};
    tbl[1] = '{1,  8'h7E, 1'b1, 1'b0, 1, 32'h0000_0001};
    tbl[2] = '{31, 8'h10, 1'b0, 1'b1, 1, 32'h7FFF_FFFF};
    tbl[3] = '{32, 8'h01, 1'b0, 1'b0, 1, 32'hFFFF_FFFF};
    tbl[4] = '{32, 8'h40, 1'b1, 1'b0, 1, 32'hFFFF_FFFF};
    tbl[5] = '{17, 8'hF0, 1'b1, 1'b0, 1, 32'h0001_FFFF};
    tbl[6] = '{0,  8'h00, 1'b0, 1'b1, 0, 32'h0000_0000};

    // Reset state
    rst_n = 1'b0;
    cyc(1'b0, '0, 1'b0);
    cyc(1'b1, 8'h99, 1'b1);
    chk("rst_data_out", data_out, '0);
    chk("rst_lane_mask", VW'(lane_mask), '0);
    chk("rst_valid_out", VW'(valid_out), '0);
    chk("rst_fill", VW'(fill), '0);
    rst_n = 1'b1;
    pulse_cnt = 0;

    // Table-driven transactions
    prev_exp = '0;
    for (int t = 0; t < 7; t++) begin
      p0 = pulse_cnt;
      for (int i = 0; i < tbl[t].n; i++) begin
        cyc(1'b1, tbl[t].base + 8'(i), tbl[t].flush_last && (i == tbl[t].n - 1));
        if (i < tbl[t].n - 1) begin
          chk($sformatf("t%0d_fill_%0d", t, i), VW'(fill), VW'(i + 1));
          chk($sformatf("t%0d_early_%0d", t, i), VW'(valid_out), '0);
        end
      end
      if (tbl[t].flush_after) cyc(1'b0, '0, 1'b1);
      chk($sformatf("t%0d_pulses", t), VW'(pulse_cnt - p0), VW'(tbl[t].exp_pulses));
      if (tbl[t].exp_pulses != 0) begin
        chk($sformatf("t%0d_mask", t), VW'(cap_mask), VW'(tbl[t].exp_mask));
        chk($sformatf("t%0d_data", t), cap_data, mkvec(tbl[t].n, tbl[t].base, 8'd1));
        chk($sformatf("t%0d_fill_after", t), VW'(fill), '0);
        prev_exp = mkvec(tbl[t].n, tbl[t].base, 8'd1);
      end
      p0 = pulse_cnt;
      cyc(1'b0, '0, 1'b0);
      cyc(1'b0, '0, 1'b0);
      chk($sformatf("t%0d_hold_pulse", t), VW'(pulse_cnt - p0), '0);
      chk($sformatf("t%0d_hold_data", t), data_out, prev_exp);
    end

    // 1..32 continuous: latency, content and downstream sum
    p0 = pulse_cnt;
    for (int i = 0; i < NUM; i++) begin
      cyc(1'b1, 8'(i + 1), 1'b0);
      if (i == NUM - 2) chk("seq1_no_early", VW'(pulse_cnt - p0), '0);
    end
    chk("seq1_valid_out", VW'(valid_out), VW'(1));
    chk("seq1_data", data_out, mkvec(NUM, 8'd1, 8'd1));
    chk("seq1_mask", VW'(lane_mask), VW'(32'hFFFF_FFFF));
    chk("seq1_fill", VW'(fill), '0);
    sum = '0;
    for (int i = 0; i < NUM; i++) sum = sum + data_out[i*BITS +: BITS];
    chk("seq1_sum", VW'(sum), VW'(8'h10));
    cyc(1'b0, '0, 1'b0);
    chk("seq1_pulse_width", VW'(valid_out), '0);

    // Same samples with random gaps of 0-3 idle cycles
    p0 = pulse_cnt;
    for (int i = 0; i < NUM; i++) begin
      repeat ($urandom_range(0, 3)) cyc(1'b0, 8'hEE, 1'b0);
      cyc(1'b1, 8'(i + 1), 1'b0);
    end
    cyc(1'b0, '0, 1'b0);
    chk("gap_pulses", VW'(pulse_cnt - p0), VW'(1));
    chk("gap_data", cap_data, mkvec(NUM, 8'd1, 8'd1));
    chk("gap_mask", VW'(cap_mask), VW'(32'hFFFF_FFFF));

    // Reset mid-fill discards the partial vector
    p0 = pulse_cnt;
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'(i + 8'h30), 1'b0);
    chk("mid_fill_10", VW'(fill), VW'(10));
    rst_n = 1'b0;
    cyc(1'b0, '0, 1'b0);
    rst_n = 1'b1;
    chk("mid_rst_fill", VW'(fill), '0);
    chk("mid_rst_data", data_out, '0);
    for (int i = 0; i < NUM; i++) cyc(1'b1, 8'h55, 1'b0);
    cyc(1'b0, '0, 1'b0);
    chk("mid_pulses", VW'(pulse_cnt - p0), VW'(1));
    chk("mid_data", cap_data, mkvec(NUM, 8'h55, 8'd0));
    chk("mid_mask", VW'(cap_mask), VW'(32'hFFFF_FFFF));

    // 64 back-to-back samples: two pulses 32 cycles apart
    p0 = pulse_cnt;
    c1 = 0;
    c2 = 0;
    for (int i = 0; i < 2 * NUM; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      if (i == NUM - 1) begin
        c1 = pulse_cyc;
        chk("b2b_first_pulse", VW'(valid_out), VW'(1));
        chk("b2b_first_data", data_out, mkvec(NUM, 8'd0, 8'd1));
      end
      if (i == NUM) chk("b2b_lane0_fill", VW'(fill), VW'(1));
      if (i == 2 * NUM - 1) begin
        c2 = pulse_cyc;
        chk("b2b_second_pulse", VW'(valid_out), VW'(1));
        chk("b2b_second_data", data_out, mkvec(NUM, 8'd32, 8'd1));
      end
    end
    chk("b2b_spacing", VW'(c2 - c1), VW'(NUM));
    chk("b2b_pulses", VW'(pulse_cnt - p0), VW'(2));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/adder_deserializer.md
Name: adder_deserializer

Overview:
- Serial-to-parallel front end for the adder tree.
- Accepts one BITS-wide sample per valid cycle and collects NUM samples into a parallel vector.
- When the vector is complete, or on an explicit flush, it presents the vector for one cycle with valid_out. That vector and pulse drive an adder of the same BITS/NUM parameters.
- A lane mask reports which lanes hold real samples, so a partial (flushed) vector is zero-padded and still sums correctly.

Parameters:
- BITS, 8, sample width in bits.
- NUM, 32, lanes per vector; must be a power of 2 and at least 2.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- valid  input  1  data_in carries a sample this cycle.
- data_in  input  BITS  sample.
- flush  input  1  close the current partial vector and emit it.
- data_out  output  BITS*NUM  parallel vector; lane i at [i*BITS +: BITS].
- lane_mask  output  NUM  bit i set means lane i of data_out holds a real sample.
- valid_out  output  1  one-cycle pulse; data_out/lane_mask are new this cycle.
- fill  output  $clog2(NUM)+1  number of samples held in the current, not yet emitted, vector.

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - Reset is synchronous and active-low on rst_n.
  - While rst_n=0 at a rising edge: data_out=0, lane_mask=0, valid_out=0, fill=0, internal shadow buffer=0.
- Reset mid-fill discards the partial vector; no emission occurs.
- Registers and states:
  - Internal shadow buffer of NUM x BITS, plus a write counter (value = fill).
  - States are implicit in fill:
    - EMPTY (fill=0).
    - FILLING (0<fill<NUM).
    - A one-cycle EMIT action.
- Sample capture:
  - On valid=1, data_in is written to shadow lane fill, and fill increments.
- Full emission:
  - Condition: valid=1 and fill=NUM-1.
  - At that edge the shadow buffer plus the current sample is copied to data_out, and lane_mask is set to all ones.
  - valid_out=1 in the following cycle (latency 1 cycle after the NUM-th sample).
  - fill returns to 0 and the shadow buffer is cleared to 0 in the same edge.
- Flush emission:
  - Condition: flush=1 and (fill>0 or valid=1).
  - The current sample, if valid, is included first.
  - data_out receives the shadow content with unfilled lanes = 0.
  - lane_mask bits [k-1:0] are set, where k = samples in the vector.
  - valid_out pulses next cycle; fill returns to 0; the shadow buffer is cleared.
- Flush with fill=0 and valid=0: no-op, no pulse.
- Flush coinciding with the NUM-th sample: exactly one emission, mask all ones.
- Back-to-back operation:
  - A sample arriving in the cycle valid_out is high is accepted into lane 0 of the next vector.
  - No sample is ever dropped; full throughput is 1 sample/cycle.
- Output hold:
  - data_out and lane_mask hold their last emitted value between pulses.
  - valid_out is high for exactly one cycle per emission.
- Pulse spacing: with continuous valid, pulses are exactly NUM cycles apart.
- Width rules: samples are stored unmodified; no arithmetic in this block.
- fill never exceeds NUM-1 at a clock edge.

Test Plan:
- Reset, then valid=1 for 32 consecutive cycles with data_in=1..32 -> one cycle after the 32nd sample:
  - valid_out=1 for 1 cycle, lane i = i+1, lane_mask=0xFFFFFFFF, fill=0.
  - A downstream adder sum = 528 mod 256 = 0x10.
- Same 32 samples with valid toggled randomly (gaps of 0-3 cycles) -> identical data_out/lane_mask, a single pulse, no early pulse.
- 5 samples 0xA0..0xA4, then flush alone -> next cycle:
  - valid_out=1, lanes 0-4 = 0xA0..0xA4, lanes 5-31 = 0, lane_mask=0x0000001F.
  - fill=0.
- flush asserted together with the 32nd sample -> exactly one pulse with mask all ones; flush at fill=0 with valid=0 -> no pulse.
- 10 samples, then rst_n=0 for 1 cycle, then 32 samples of 0x55 -> no pulse from the partial vector, then one pulse with all lanes 0x55.
- 64 continuous samples 0..63 -> two pulses 32 cycles apart:
  - First vector has lanes 0..31; second has lanes 32..63.
  - Sample 32, arriving in the pulse cycle, is in lane 0 of the second vector.
